// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder: FSM state encodings.
package dmem_responder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM with a registered read port; contents are never reset.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory target: one word transaction per handshake, programmable
// wait states, then a one-cycle response carrying read data or an error flag.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic       NO_WAIT  = (WAIT_CYCLES == 0);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              wen_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;

    logic              accept;
    logic              enter_resp;
    logic              acc_wen;
    logic              acc_err;
    logic [31:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic [31:0]       arr_rdata;
    logic              arr_we;
    logic              arr_re;

    function automatic logic addr_err(input logic [31:0] a);
        logic [31:0] hi;
        hi = a >> (ADDR_W + 2);
        return (a[1:0] != 2'b00) || (hi != 32'd0);
    endfunction

    assign accept     = req_valid && (state == ST_IDLE);
    assign enter_resp = (accept && NO_WAIT) || ((state == ST_WAIT) && (cnt == 4'd0));

    // With zero wait states RESP is entered on the accept edge itself, before the
    // capture registers load, so the array must see the live request.
    assign acc_wen   = (state == ST_IDLE) ? req_wen   : wen_q;
    assign acc_addr  = (state == ST_IDLE) ? req_addr  : addr_q;
    assign acc_wdata = (state == ST_IDLE) ? req_wdata : wdata_q;
    assign acc_err   = addr_err(acc_addr);

    assign arr_we = enter_resp && acc_wen  && !acc_err && reset;
    assign arr_re = enter_resp && !acc_wen && !acc_err && reset;

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clock (clock),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (acc_addr[ADDR_W+1:2]),
        .wdata (acc_wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            wen_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        wen_q   <= req_wen;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (NO_WAIT) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Response fields are only driven while in RESP so they fall to zero on exit and on reset.
    assign req_ready  = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign resp_err   = resp_valid && addr_err(addr_q);
    assign resp_rdata = (resp_valid && !wen_q && !resp_err) ? arr_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: two responders (0 and 2 wait states) share stimulus and are
// compared every cycle against a transaction-level model, plus directed literal checks.
module tb_dmem_responder;

    localparam int ADDR_W = 8;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    // index 0: WAIT_CYCLES=0, index 1: WAIT_CYCLES=2
    logic        rr [2];
    logic        rv [2];
    logic        re [2];
    logic        bz [2];
    logic [31:0] rd [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) u_dut0 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rr[0]),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv[0]), .resp_rdata(rd[0]), .resp_err(re[0]), .busy(bz[0])
    );

    dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(2)) u_dut2 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rr[1]),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv[1]), .resp_rdata(rd[1]), .resp_err(re[1]), .busy(bz[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int wof(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    // ---------------- transaction-level reference model ----------------
    logic [31:0] mmem  [2][256];
    bit          mknown[2][256];
    bit          act   [2];
    int          ae    [2];
    bit          me    [2];
    logic [31:0] mrd   [2];
    bit          mk    [2];
    bit          pv    [2];
    int          pe    [2];
    logic [7:0]  pidx  [2];
    logic [31:0] pd    [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            act[i] = 0; pv[i] = 0; ae[i] = 0; me[i] = 0; mrd[i] = 0; mk[i] = 0;
            for (int j = 0; j < 256; j++) mknown[i][j] = 0;
        end
    end

    always @(posedge clock) begin
        logic       e;
        logic [7:0] idx;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                act[i] = 0;
                pv[i]  = 0;
            end else begin
                // idle again W+2 edges after an accept
                if ((!act[i] || cyc >= ae[i] + wof(i) + 2) && req_valid) begin
                    e   = (req_addr[1:0] != 2'b00) || ((req_addr >> (ADDR_W + 2)) != 32'd0);
                    idx = req_addr[9:2];
                    act[i] = 1;
                    ae[i]  = cyc;
                    me[i]  = e;
                    if (req_wen) begin
                        mrd[i] = 32'd0;
                        mk[i]  = 1;
                        if (!e) begin
                            pv[i] = 1; pe[i] = cyc + wof(i); pidx[i] = idx; pd[i] = req_wdata;
                        end
                    end else begin
                        mrd[i] = e ? 32'd0 : mmem[i][idx];
                        mk[i]  = e || mknown[i][idx];
                    end
                end
                if (pv[i] && cyc == pe[i]) begin
                    mmem[i][pidx[i]]   = pd[i];
                    mknown[i][pidx[i]] = 1;
                    pv[i] = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        bit          ev, eb;
        logic [31:0] erd;
        bit          ee;
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                ev = 0; eb = 0; erd = 0; ee = 0;
            end else if (act[i] && cyc <= ae[i] + wof(i)) begin
                eb  = 1;
                ev  = (cyc == ae[i] + wof(i));
                ee  = ev && me[i];
                erd = ev ? mrd[i] : 32'd0;
            end else begin
                ev = 0; eb = 0; erd = 0; ee = 0;
            end
            chk($sformatf("dut%0d req_ready", i), 32'(rr[i]), 32'(!eb));
            chk($sformatf("dut%0d busy", i), 32'(bz[i]), 32'(eb));
            chk($sformatf("dut%0d resp_valid", i), 32'(rv[i]), 32'(ev));
            chk($sformatf("dut%0d resp_err", i), 32'(re[i]), 32'(ee));
            if (!(ev && !mk[i]))
                chk($sformatf("dut%0d resp_rdata", i), rd[i], erd);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_ready(input int sel);
        int n = 0;
        while (!rr[sel] && n < 50) begin
            @(posedge clock); #1; n++;
        end
        if (!rr[sel]) chk("ready timeout", 32'(rr[sel]), 32'd1);
    endtask

    task automatic txn(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rdat, output logic err, output int lat);
        wait_ready(sel);
        req_valid = 1; req_wen = w; req_addr = a; req_wdata = d;
        @(posedge clock); #1;
        req_valid = 0;
        lat = 1;
        while (!rv[sel] && lat < 40) begin
            @(posedge clock); #1; lat++;
        end
        if (!rv[sel]) chk("response timeout", 32'(rv[sel]), 32'd1);
        rdat = rd[sel];
        err  = re[sel];
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rdat;
        logic        err;
        int          lat;
        int          seen;
        int          r;

        reset = 1; req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0;
        #1 reset = 0;
        repeat (3) @(posedge clock);
        #1 reset = 1;

        // 1: write then read, 2 wait states
        txn(1, 1, 32'h10, 32'hDEADBEEF, rdat, err, lat);
        chk("t1 write latency", 32'(lat), 32'd3);
        chk("t1 write err", 32'(err), 32'd0);
        txn(1, 0, 32'h10, 32'h0, rdat, err, lat);
        chk("t1 read latency", 32'(lat), 32'd3);
        chk("t1 read data", rdat, 32'hDEADBEEF);
        chk("t1 read err", 32'(err), 32'd0);

        // 2: misaligned write leaves the array untouched
        txn(1, 1, 32'h20, 32'hDEADBEEF, rdat, err, lat);
        txn(1, 1, 32'h22, 32'h12345678, rdat, err, lat);
        chk("t2 misaligned err", 32'(err), 32'd1);
        chk("t2 misaligned rdata", rdat, 32'd0);
        txn(1, 0, 32'h20, 32'h0, rdat, err, lat);
        chk("t2 read 0x20", rdat, 32'hDEADBEEF);

        // 3: out-of-range read
        txn(1, 0, 32'h400, 32'h0, rdat, err, lat);
        chk("t3 oor err", 32'(err), 32'd1);
        chk("t3 oor rdata", rdat, 32'd0);
        @(posedge clock); #1;
        chk("t3 back to idle ready", 32'(rr[1]), 32'd1);
        chk("t3 back to idle busy", 32'(bz[1]), 32'd0);

        txn(1, 1, 32'h14, 32'h14141414, rdat, err, lat);
        txn(1, 1, 32'h30, 32'h0BADF00D, rdat, err, lat);

        // 4: req_valid held across two reads
        wait_ready(1);
        req_valid = 1; req_wen = 0; req_addr = 32'h10;
        @(posedge clock); #1;
        req_addr = 32'h14;
        for (int k = 0; k < 3; k++) begin
            chk("t4 ready low", 32'(rr[1]), 32'd0);
            chk("t4 busy high", 32'(bz[1]), 32'd1);
            if (k == 2) chk("t4 first rdata", rd[1], 32'hDEADBEEF);
            @(posedge clock); #1;
        end
        chk("t4 idle gap ready", 32'(rr[1]), 32'd1);
        @(posedge clock); #1;
        chk("t4 second accept at 4", 32'(bz[1]), 32'd1);
        req_valid = 0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("t4 second resp_valid", 32'(rv[1]), 32'd1);
        chk("t4 second rdata", rd[1], 32'h14141414);

        // 5: zero wait states
        txn(0, 0, 32'h10, 32'h0, rdat, err, lat);
        chk("t5 latency", 32'(lat), 32'd1);
        chk("t5 rdata", rdat, 32'hDEADBEEF);
        @(posedge clock); #1;
        chk("t5 idle after resp", 32'(rr[0]), 32'd1);
        chk("t5 resp dropped", 32'(rv[0]), 32'd0);

        // 6: reset during WAIT drops the pending write
        wait_ready(1);
        req_valid = 1; req_wen = 1; req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
        seen = 0;
        @(posedge clock); #1;
        req_valid = 0;
        if (rv[1]) seen++;
        @(posedge clock); #1;
        if (rv[1]) seen++;
        reset = 0;
        #1;
        chk("t6 reset ready", 32'(rr[1]), 32'd1);
        chk("t6 reset busy", 32'(bz[1]), 32'd0);
        chk("t6 reset resp_valid", 32'(rv[1]), 32'd0);
        chk("t6 reset rdata", rd[1], 32'd0);
        chk("t6 reset err", 32'(re[1]), 32'd0);
        @(posedge clock); @(posedge clock); #1;
        reset = 1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clock); #1;
            if (rv[1]) seen++;
        end
        chk("t6 no aborted resp", 32'(seen), 32'd0);
        txn(1, 0, 32'h30, 32'h0, rdat, err, lat);
        chk("t6 read 0x30", rdat, 32'h0BADF00D);

        // randomized traffic checked by the per-cycle compare
        for (int k = 0; k < 800; k++) begin
            @(posedge clock); #1;
            reset     = ($urandom_range(0, 119) != 0);
            req_valid = $urandom_range(0, 1) == 1;
            req_wen   = $urandom_range(0, 1) == 1;
            req_wdata = $urandom;
            r = $urandom_range(0, 9);
            if (r < 8)       req_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            else if (r == 8) req_addr = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
            else             req_addr = 32'h400 + 32'($urandom_range(0, 255)) * 4;
        end
        @(posedge clock); #1;
        reset = 1; req_valid = 0;
        repeat (10) @(posedge clock);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
